alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 203 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked RV32I/M execute-stage ALU: base ops in one cycle, M ops by iterative shift-add / restoring divide.
// Define ALU_SEQ_FAST_MUL_EN to replace the iterative multiply with a single-cycle combinational multiplier.
module alu_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 5,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  busy
);
  localparam int W   = DATA_WIDTH;
  localparam int SHW = $clog2(DATA_WIDTH);

  localparam logic [OP_WIDTH-1:0] OP_ADD    = OP_WIDTH'(5'b00000);
  localparam logic [OP_WIDTH-1:0] OP_SUB    = OP_WIDTH'(5'b00001);
  localparam logic [OP_WIDTH-1:0] OP_SLL    = OP_WIDTH'(5'b00010);
  localparam logic [OP_WIDTH-1:0] OP_SLT    = OP_WIDTH'(5'b00011);
  localparam logic [OP_WIDTH-1:0] OP_SLTU   = OP_WIDTH'(5'b00100);
  localparam logic [OP_WIDTH-1:0] OP_XOR    = OP_WIDTH'(5'b00101);
  localparam logic [OP_WIDTH-1:0] OP_SRL    = OP_WIDTH'(5'b00110);
  localparam logic [OP_WIDTH-1:0] OP_SRA    = OP_WIDTH'(5'b00111);
  localparam logic [OP_WIDTH-1:0] OP_OR     = OP_WIDTH'(5'b01000);
  localparam logic [OP_WIDTH-1:0] OP_AND    = OP_WIDTH'(5'b01001);
  localparam logic [OP_WIDTH-1:0] OP_MUL    = OP_WIDTH'(5'b10000);
  localparam logic [OP_WIDTH-1:0] OP_MULH   = OP_WIDTH'(5'b10001);
  localparam logic [OP_WIDTH-1:0] OP_MULHSU = OP_WIDTH'(5'b10010);
  localparam logic [OP_WIDTH-1:0] OP_DIV    = OP_WIDTH'(5'b10100);
  localparam logic [OP_WIDTH-1:0] OP_REM    = OP_WIDTH'(5'b10110);
  localparam logic [OP_WIDTH-1:0] OP_REMU   = OP_WIDTH'(5'b10111);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // flush overrides both sides and kills whatever is held or in progress.
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_next;

  logic [W-1:0]         hi_q, lo_q, opd_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 is_div_q, neg_q, mul_lo_q, rem_q;

  logic                 accept, is_m, is_div_op, a_signed, b_signed, a_neg, b_neg;
  logic                 div_by_zero, div_ovf, go_calc, neg_in;
  logic [W-1:0]         a_mag, b_mag, base_res, imm_res;
  logic [SHW-1:0]       shamt;

  assign accept   = (state == IDLE) && in_valid && !flush;
  assign in_ready = (state == IDLE);
  assign busy     = (state == CALC);
  assign out_valid = (state == DONE);

  // Accept-time decode: operand magnitudes, result sign and early-exit division cases
  always_comb begin
    is_m        = (op >= OP_MUL) && (op <= OP_REMU);
    is_div_op   = is_m && op[2];
    a_signed    = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    b_signed    = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    a_neg       = a_signed && src_a[W-1];
    b_neg       = b_signed && src_b[W-1];
    a_mag       = a_neg ? -src_a : src_a;
    b_mag       = b_neg ? -src_b : src_b;
    neg_in      = (is_div_op && op[1]) ? a_neg : (a_neg ^ b_neg);
    div_by_zero = (src_b == '0);
    div_ovf     = ((op == OP_DIV) || (op == OP_REM)) &&
                  (src_a == {1'b1, {(W-1){1'b0}}}) && (src_b == '1);
`ifdef ALU_SEQ_FAST_MUL_EN
    go_calc     = is_div_op && !div_by_zero && !div_ovf;
`else
    go_calc     = is_m && !(is_div_op && (div_by_zero || div_ovf));
`endif
  end

  always_comb begin
    shamt    = src_b[SHW-1:0];
    base_res = '0;
    case (op)
      OP_ADD:  base_res = src_a + src_b;
      OP_SUB:  base_res = src_a - src_b;
      OP_SLL:  base_res = src_a << shamt;
      OP_SLT:  base_res[0] = $signed(src_a) < $signed(src_b);
      OP_SLTU: base_res[0] = src_a < src_b;
      OP_XOR:  base_res = src_a ^ src_b;
      OP_SRL:  base_res = src_a >> shamt;
      OP_SRA:  base_res = $unsigned($signed(src_a) >>> shamt);
      OP_OR:   base_res = src_a | src_b;
      OP_AND:  base_res = src_a & src_b;
      default: base_res = '0;
    endcase
  end

`ifdef ALU_SEQ_FAST_MUL_EN
  logic signed [2*W-1:0] fast_a, fast_b, fast_p;
  always_comb begin
    fast_a = {{W{a_neg}}, src_a};
    fast_b = {{W{b_neg}}, src_b};
    fast_p = fast_a * fast_b;
  end
`endif

  always_comb begin
    imm_res = base_res;
    if (is_div_op) begin
      if (div_by_zero) imm_res = op[1] ? src_a : '1;
      else             imm_res = op[1] ? '0 : src_a;
    end
`ifdef ALU_SEQ_FAST_MUL_EN
    else if (is_m) begin
      imm_res = (op[1:0] == 2'b00) ? fast_p[W-1:0] : fast_p[2*W-1:W];
    end
`endif
  end

  // One iteration: mul adds the multiplicand into the high half then shifts right;
  // div shifts the next dividend bit into the partial remainder and trial-subtracts.
  logic [W:0]     mul_sum, div_sh;
  logic [W-1:0]   div_diff, hi_n, lo_n, fin_res;
  logic [2*W-1:0] prod;
  logic           div_ge;

  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    div_sh   = {hi_q, lo_q[W-1]};
    div_ge   = div_sh >= {1'b0, opd_q};
    div_diff = div_sh[W-1:0] - opd_q;
    if (is_div_q) begin
      hi_n = div_ge ? div_diff : div_sh[W-1:0];
      lo_n = {lo_q[W-2:0], div_ge};
    end else begin
      hi_n = mul_sum[W:1];
      lo_n = {mul_sum[0], lo_q[W-1:1]};
    end
    prod = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
    if (is_div_q) begin
      if (rem_q) fin_res = neg_q ? -hi_n : hi_n;
      else       fin_res = neg_q ? -lo_n : lo_n;
    end else begin
      fin_res = mul_lo_q ? prod[W-1:0] : prod[2*W-1:W];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = go_calc ? CALC : DONE;
      CALC: begin
        if (flush)                         state_next = IDLE;
        else if (cnt_q == CNT_WIDTH'(1))   state_next = DONE;
      end
      DONE: if (flush || out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q     <= '0;
      lo_q     <= '0;
      opd_q    <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      mul_lo_q <= 1'b0;
      rem_q    <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
    end else if (accept) begin
      hi_q     <= '0;
      lo_q     <= is_div_op ? a_mag : b_mag;
      opd_q    <= is_div_op ? b_mag : a_mag;
      cnt_q    <= CNT_WIDTH'(DATA_WIDTH);
      is_div_q <= is_div_op;
      neg_q    <= neg_in;
      mul_lo_q <= (op[1:0] == 2'b00);
      rem_q    <= op[1];
      if (!go_calc) begin
        result <= imm_res;
        zero   <= (imm_res == '0);
      end
    end else if (state == CALC && !flush) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q - CNT_WIDTH'(1);
      if (cnt_q == CNT_WIDTH'(1)) begin
        result <= fin_res;
        zero   <= (fin_res == '0);
      end
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq: op table plus reset, backpressure and flush sequences.
module tb_alu_seq;
  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, SLL = 5'b00010, SLT = 5'b00011,
                         SLTU = 5'b00100, XOR_ = 5'b00101, SRL = 5'b00110, SRA = 5'b00111,
                         OR_ = 5'b01000, AND_ = 5'b01001, MUL = 5'b10000, MULH = 5'b10001,
                         MULHSU = 5'b10010, MULHU = 5'b10011, DIV = 5'b10100, DIVU = 5'b10101,
                         REM = 5'b10110, REMU = 5'b10111;
`ifdef ALU_SEQ_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;
  localparam int NV = 24;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    int          lat;
  } vec_t;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, zero, busy;
  logic [4:0]  op;
  logic [31:0] src_a, src_b, result;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  vec_t vecs[NV];

  alu_seq dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output int lat,
                        output logic busy1);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    op = o; src_a = a; src_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    src_a = $urandom; src_b = $urandom; op = 5'($urandom_range(0, 31));
    busy1 = busy;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    res = result; z = zero;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] res, exp_r;
    logic        z, b1, seen;
    int          lat;

    vecs[0]  = '{SUB,    32'd3,        32'd3,        32'd0,        1'b1, 1};
    vecs[1]  = '{SRA,    32'h80000000, 32'h24,       32'hF8000000, 1'b0, 1};
    vecs[2]  = '{SLT,    32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1};
    vecs[3]  = '{SLTU,   32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1};
    vecs[4]  = '{SLL,    32'd1,        32'h21,       32'd2,        1'b0, 1};
    vecs[5]  = '{SRL,    32'h80000000, 32'd31,       32'd1,        1'b0, 1};
    vecs[6]  = '{XOR_,   32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0, 1};
    vecs[7]  = '{OR_,    32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0, 1};
    vecs[8]  = '{ADD,    32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1};
    vecs[9]  = '{5'b11111, 32'd1,      32'd1,        32'd0,        1'b1, 1};
    vecs[10] = '{MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0, MUL_LAT};
    vecs[11] = '{MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0, MUL_LAT};
    vecs[12] = '{MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, MUL_LAT};
    vecs[13] = '{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, MUL_LAT};
    vecs[14] = '{DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, DIV_LAT};
    vecs[15] = '{REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, DIV_LAT};
    vecs[16] = '{DIVU,   32'd100,      32'd0,        32'hFFFFFFFF, 1'b0, 1};
    vecs[17] = '{REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b1, 1};
    vecs[18] = '{DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1};
    vecs[19] = '{REMU,   32'd100,      32'd0,        32'd100,      1'b0, 1};
    vecs[20] = '{DIVU,   32'd100,      32'd7,        32'd14,       1'b0, DIV_LAT};
    vecs[21] = '{REMU,   32'd100,      32'd7,        32'd2,        1'b0, DIV_LAT};
    vecs[22] = '{AND_,   32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0, 1};
    vecs[23] = '{DIV,    32'd7,        32'd0,        32'hFFFFFFFF, 1'b0, 1};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_zero", {31'd0, zero}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      exp_q.push_back(vecs[i].res);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, z, lat, b1);
      exp_r = exp_q.pop_front();
      chk($sformatf("v%0d_result", i), res, exp_r);
      chk($sformatf("v%0d_zero", i), {31'd0, z}, {31'd0, vecs[i].z});
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_busy", i), {31'd0, b1}, {31'd0, (vecs[i].lat > 1)});
      chk($sformatf("v%0d_idle_after_take", i), {30'd0, in_ready, out_valid}, 32'b10);
    end

    // Reset in the 10th CALC cycle of a DIV: no partial result may appear
    op = DIV; src_a = 32'hFFFFFFF9; src_b = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_result", result, 32'd0);
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("rst_mid_hold_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(32'd12);
    run_op(ADD, 32'd5, 32'd7, res, z, lat, b1);
    chk("post_reset_add", res, exp_q.pop_front());
    chk("post_reset_add_latency", 32'(lat), 32'd1);

    // Backpressure on a DIVU, with a competing request that must be ignored
    op = DIVU; src_a = 32'd100; src_b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("bp_latency", 32'(lat), 32'd33);
    op = ADD; src_a = 32'd1; src_b = 32'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_result", i), result, 32'd14);
      chk($sformatf("bp_hold%0d_flags", i), {30'd0, out_valid, in_ready}, 32'b10);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_take_no_reaccept", {29'd0, out_valid, in_ready, busy}, 32'b010);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_idle_stays", {30'd0, out_valid, in_ready}, 32'b01);
    chk("bp_result_holds", result, 32'd14);

    // Flush in CALC cycle 5 alongside a new request
    op = DIVU; src_a = 32'd200; src_b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("flush_busy_before", {31'd0, busy}, 32'd1);
    flush = 1'b1; in_valid = 1'b1; op = AND_; src_a = 32'hFF; src_b = 32'hFF;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_flags", {29'd0, in_ready, out_valid, busy}, 32'b100);
    chk("flush_result_holds", result, 32'd14);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen = seen | out_valid | busy;
    end
    chk("flush_no_late_result", {31'd0, seen}, 32'd0);
    exp_q.push_back(32'h30);
    run_op(AND_, 32'hF0, 32'h3C, res, z, lat, b1);
    chk("flush_then_and", res, exp_q.pop_front());
    chk("flush_then_and_latency", 32'(lat), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
